// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared score entry layout, terminator key and recorder state encoding
package score_pkg;

   localparam logic [3:0] REST     = 4'd0;
   // Terminator entry is {TERM_KEY, zero length}; playback stops on it.
   localparam logic [7:0] TERM_KEY = {4'd0, REST};
   localparam int         LEN_LSB  = 0;

   function automatic int note_lsb(input int len_w);
      return len_w;
   endfunction

   function automatic int oct_lsb(input int len_w);
      return len_w + 4;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRACK,
      ST_FLUSH,
      ST_TERM,
      ST_FULL_HOLD
   } state_e;

endpackage

// File: rtl/seg_timer.sv
// rtl/seg_timer.sv - saturating segment length counter in ms
module seg_timer #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [LEN_W-1:0] len_nxt,
   output logic             sat
);

   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_d;

   // len_nxt is the length including this cycle's tick, so a closing segment sees it.
   always_comb begin
      len_nxt = len_q;
      if (inc && !(&len_q)) begin
         len_nxt = len_q + LEN_W'(1);
      end
      sat   = &len_nxt;
      len_d = clr ? '0 : len_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0;
      end else begin
         len_q <= len_d;
      end
   end

endmodule

// File: rtl/score_recorder.sv
// rtl/score_recorder.sv - records keypad note/rest segments into score RAM entries
module score_recorder
   import score_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_1ms,
   input  logic              en,
   input  logic [3:0]        note,
   input  logic [3:0]        octave,
   output logic              score_we,
   output logic [ADDR_W-1:0] score_addr,
   output logic [8+LEN_W-1:0] score_data,
   output logic [ADDR_W-1:0] entry_count,
   output logic              recording,
   output logic              full,
   output logic              done
);

   localparam int DATA_W   = 8 + LEN_W;
   localparam int NOTE_LSB = note_lsb(LEN_W);
   localparam int OCT_LSB  = oct_lsb(LEN_W);
   localparam logic [ADDR_W-1:0] LAST_SEG = {{(ADDR_W-1){1'b1}}, 1'b0};

   state_e            state_q, state_d;
   logic              en_prev_q;
   logic [7:0]        cur_seg_q, cur_seg_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              full_q, full_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic              recording_q, recording_d;

   logic              tmr_clr, tmr_inc, sat;
   logic [LEN_W-1:0]  len_nxt;
   logic [7:0]        key;
   logic              seg_wr;
   logic [DATA_W-1:0] seg_data;

   seg_timer #(.LEN_W(LEN_W)) u_seg_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .len_nxt (len_nxt),
      .sat     (sat)
   );

   assign key = {octave, note};

   always_comb begin
      seg_data = '0;
      seg_data[LEN_LSB +: LEN_W] = len_nxt;
      seg_data[NOTE_LSB +: 4]    = cur_seg_q[3:0];
      seg_data[OCT_LSB +: 4]     = cur_seg_q[7:4];
   end

   always_comb begin
      state_d   = state_q;
      cur_seg_d = cur_seg_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      full_d    = full_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      done_d    = 1'b0;
      tmr_clr   = 1'b0;
      tmr_inc   = 1'b0;
      seg_wr    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en && !en_prev_q) begin
               ptr_d     = '0;
               count_d   = '0;
               full_d    = 1'b0;
               cur_seg_d = key;
               tmr_clr   = 1'b1;
               state_d   = ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (!en) begin
               state_d = ST_FLUSH;
            end else begin
               tmr_inc = tick_1ms;
               // Saturation restarts the same key; a change in that cycle still gives one write.
               if (key != cur_seg_q || sat) begin
                  tmr_clr   = 1'b1;
                  cur_seg_d = key;
                  seg_wr    = (len_nxt != '0);
               end
            end
         end
         ST_FLUSH: begin
            tmr_clr = 1'b1;
            seg_wr  = (len_nxt != '0);
            state_d = ST_TERM;
         end
         ST_TERM: begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            data_d  = {TERM_KEY, {LEN_W{1'b0}}};
            done_d  = 1'b1;
            state_d = full_q ? ST_FULL_HOLD : ST_IDLE;
         end
         ST_FULL_HOLD: begin
            if (!en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (seg_wr) begin
         we_d    = 1'b1;
         addr_d  = ptr_q;
         data_d  = seg_data;
         ptr_d   = ptr_q + ADDR_W'(1);
         count_d = count_q + ADDR_W'(1);
         if (ptr_q == LAST_SEG) begin
            full_d  = 1'b1;
            state_d = ST_TERM;
         end
      end

      recording_d = (state_d == ST_TRACK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         en_prev_q   <= 1'b0;
         cur_seg_q   <= '0;
         ptr_q       <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         recording_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         en_prev_q   <= en;
         cur_seg_q   <= cur_seg_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         done_q      <= done_d;
         recording_q <= recording_d;
      end
   end

   assign score_we    = we_q;
   assign score_addr  = addr_q;
   assign score_data  = data_q;
   assign entry_count = count_q;
   assign recording   = recording_q;
   assign full        = full_q;
   assign done        = done_q;

endmodule

// File: tb/tb_score_recorder.sv
// tb/tb_score_recorder.sv - scoreboard bench for score_recorder
module tb_score_recorder;
   import score_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       en_a = 1'b0;
   logic       en_b = 1'b0;
   logic [3:0] note = 4'd0;
   logic [3:0] octave = 4'd0;

   logic        we_a, rec_a, full_a, done_a;
   logic [2:0]  addr_a, cnt_a;
   logic [23:0] data_a;
   logic        we_b, rec_b, full_b, done_b;
   logic [7:0]  addr_b, cnt_b;
   logic [11:0] data_b;

   score_recorder #(.ADDR_W(3), .LEN_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .tick_1ms(tick), .en(en_a), .note(note), .octave(octave),
      .score_we(we_a), .score_addr(addr_a), .score_data(data_a), .entry_count(cnt_a),
      .recording(rec_a), .full(full_a), .done(done_a)
   );

   score_recorder #(.ADDR_W(8), .LEN_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .tick_1ms(tick), .en(en_b), .note(note), .octave(octave),
      .score_we(we_b), .score_addr(addr_b), .score_data(data_b), .entry_count(cnt_b),
      .recording(rec_b), .full(full_b), .done(done_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  addr;
      logic [23:0] data;
   } wr_t;

   wr_t q_a[$];
   wr_t q_b[$];
   int  tests_run = 0;
   int  tests_failed = 0;
   int  done_a_n = 0;
   int  done_b_n = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_a(input int addr, input int o, input int n, input int len);
      wr_t e;
      e.addr = 8'(addr);
      e.data = {4'(o), 4'(n), 16'(len)};
      q_a.push_back(e);
   endtask

   task automatic push_b(input int addr, input int o, input int n, input int len);
      wr_t e;
      e.addr = 8'(addr);
      e.data = {12'd0, 4'(o), 4'(n), 4'(len)};
      q_b.push_back(e);
   endtask

   task automatic mon_a();
      wr_t e;
      forever begin
         @(negedge clk);
         if (we_a) begin
            if (q_a.size() == 0) begin
               check_eq("unexpected_wr_a", {5'd0, addr_a, data_a}, 32'hFFFF_FFFF);
            end else begin
               e = q_a.pop_front();
               check_eq("wr_a_addr", 32'(addr_a), 32'(e.addr));
               check_eq("wr_a_data", 32'(data_a), 32'(e.data));
            end
         end
         if (done_a) done_a_n++;
      end
   endtask

   task automatic mon_b();
      wr_t e;
      forever begin
         @(negedge clk);
         if (we_b) begin
            if (q_b.size() == 0) begin
               check_eq("unexpected_wr_b", {12'd0, addr_b, data_b}, 32'hFFFF_FFFF);
            end else begin
               e = q_b.pop_front();
               check_eq("wr_b_addr", 32'(addr_b), 32'(e.addr));
               check_eq("wr_b_data", 32'(data_b), 32'(e.data));
            end
         end
         if (done_b) done_b_n++;
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_key(input int o, input int n);
      octave = 4'(o);
      note   = 4'(n);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
   endtask

   task automatic change(input int o, input int n);
      set_key(o, n);
      step();
   endtask

   task automatic stop_a(input string tag, input int exp_cnt, input int base);
      en_a = 1'b0;
      step(8);
      check_eq({tag, "_done"}, 32'(done_a_n - base), 32'd1);
      check_eq({tag, "_count"}, 32'(cnt_a), 32'(exp_cnt));
      check_eq({tag, "_drain"}, 32'(q_a.size()), 32'd0);
   endtask

   initial begin
      int base;
      fork
         mon_a();
         mon_b();
      join_none

      step(3);
      check_eq("rst_we", {31'd0, we_a | we_b}, 32'd0);
      check_eq("rst_addr", {21'd0, addr_a, addr_b}, 32'd0);
      check_eq("rst_data_a", 32'(data_a), 32'd0);
      check_eq("rst_data_b", 32'(data_b), 32'd0);
      check_eq("rst_cnt", {21'd0, cnt_a, cnt_b}, 32'd0);
      check_eq("rst_flags", {26'd0, rec_a, full_a, done_a, rec_b, full_b, done_b}, 32'd0);
      rst_n = 1'b1;
      step(2);

      // basic take
      push_a(0, 4, 1, 300);
      push_a(1, 0, REST, 50);
      push_a(2, 4, 5, 120);
      push_a(3, 0, 0, 0);
      base = done_a_n;
      set_key(4, 1);
      en_a = 1'b1;
      step();
      check_eq("basic_recording", 32'(rec_a), 32'd1);
      ticks(300);
      change(0, REST);
      ticks(50);
      change(4, 5);
      ticks(120);
      stop_a("basic", 3, base);

      // glitch drop, then a one-clk en drop with en held high afterwards
      push_a(0, 1, 1, 5);
      push_a(1, 1, 2, 7);
      push_a(2, 0, 0, 0);
      base = done_a_n;
      set_key(1, 1);
      en_a = 1'b1;
      step();
      ticks(5);
      change(1, 3);
      change(1, 2);
      ticks(7);
      en_a = 1'b0;
      step();
      en_a = 1'b1;
      ticks(6);
      check_eq("glitch_done", 32'(done_a_n - base), 32'd1);
      check_eq("glitch_count", 32'(cnt_a), 32'd2);
      check_eq("glitch_no_retake", 32'(rec_a), 32'd0);
      check_eq("glitch_drain", 32'(q_a.size()), 32'd0);
      en_a = 1'b0;
      step(2);

      // capacity: 9 segments into an 8-entry score
      for (int s = 0; s < 7; s++) push_a(s, 1, s + 1, 2);
      push_a(7, 0, 0, 0);
      base = done_a_n;
      set_key(1, 1);
      en_a = 1'b1;
      step();
      for (int s = 0; s < 9; s++) begin
         if (s > 0) change(1, s + 1);
         ticks(2);
      end
      check_eq("full_flag", 32'(full_a), 32'd1);
      check_eq("full_count", 32'(cnt_a), 32'd7);
      check_eq("full_recording", 32'(rec_a), 32'd0);
      check_eq("full_done_early", 32'(done_a_n - base), 32'd1);
      stop_a("full", 7, base);
      check_eq("full_sticky", 32'(full_a), 32'd1);

      // tick and change in the same cycle
      push_a(0, 2, 1, 10);
      push_a(1, 2, 2, 5);
      push_a(2, 0, 0, 0);
      base = done_a_n;
      set_key(2, 1);
      en_a = 1'b1;
      step();
      check_eq("full_cleared", 32'(full_a), 32'd0);
      ticks(9);
      set_key(2, 2);
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      ticks(5);
      stop_a("simul", 2, base);

      // saturation on the LEN_W=4 build
      push_b(0, 3, 7, 15);
      push_b(1, 3, 7, 5);
      push_b(2, 0, 0, 0);
      base = done_b_n;
      set_key(3, 7);
      en_b = 1'b1;
      step();
      ticks(20);
      en_b = 1'b0;
      step(8);
      check_eq("sat_done", 32'(done_b_n - base), 32'd1);
      check_eq("sat_count", 32'(cnt_b), 32'd2);
      check_eq("sat_drain", 32'(q_b.size()), 32'd0);

      // reset while a segment write is on the bus
      set_key(5, 6);
      en_a = 1'b1;
      step();
      ticks(5);
      set_key(5, 7);
      @(posedge clk);
      #2;
      check_eq("prerst_we", 32'(we_a), 32'd1);
      rst_n = 1'b0;
      en_a  = 1'b0;
      #1;
      check_eq("midrst_we", 32'(we_a), 32'd0);
      check_eq("midrst_addr_data", {5'd0, addr_a, data_a}, 32'd0);
      check_eq("midrst_flags", {25'd0, cnt_a, rec_a, full_a, done_a}, 32'd0);
      step(2);
      rst_n = 1'b1;
      step(2);
      push_a(0, 5, 6, 3);
      push_a(1, 0, 0, 0);
      base = done_a_n;
      set_key(5, 6);
      en_a = 1'b1;
      step();
      ticks(3);
      stop_a("restart", 1, base);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
